// File: rtl/mxint_exp_arbiter.sv
// mxint_exp_arbiter: round-robin sharing of one mxint_exp datapath between
// NUM_REQ requesters, with an in-order tag FIFO that routes each result back
// to the requester that issued the block.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   req_mdata/req_edata/req_valid per-requester MX blocks (requester r owns
//                                 mantissas r*BLOCK_SIZE .. r*BLOCK_SIZE+BLOCK_SIZE-1)
//   req_ready                     one-hot grant, or zero
//   exp_mdata/exp_edata/exp_valid registered block towards the exp unit
//   exp_ready                     exp unit accepts the block
//   ret_mdata/ret_edata/ret_valid results from the exp unit (in order)
//   ret_ready                     this block accepts the result
//   resp_mdata/resp_edata         results broadcast to all consumers
//   resp_valid                    one-hot owner of the current result
//   resp_ready                    per-consumer ready
//   inflight                      tag FIFO occupancy
//   err_orphan                    sticky: result arrived with no outstanding tag
module mxint_exp_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned MAN_WIDTH     = 4,
    parameter int unsigned EXP_WIDTH     = 8,
    parameter int unsigned OUT_MAN_WIDTH = 4,
    parameter int unsigned BLOCK_SIZE    = 4,
    parameter int unsigned MAX_INFLIGHT  = 4
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [NUM_REQ*BLOCK_SIZE-1:0][MAN_WIDTH-1:0]   req_mdata,
    input  logic [NUM_REQ-1:0][EXP_WIDTH-1:0]              req_edata,
    input  logic [NUM_REQ-1:0]                             req_valid,
    output logic [NUM_REQ-1:0]                             req_ready,
    output logic [BLOCK_SIZE-1:0][MAN_WIDTH-1:0]           exp_mdata,
    output logic [EXP_WIDTH-1:0]                           exp_edata,
    output logic                                           exp_valid,
    input  logic                                           exp_ready,
    input  logic [BLOCK_SIZE-1:0][OUT_MAN_WIDTH-1:0]       ret_mdata,
    input  logic [BLOCK_SIZE-1:0][EXP_WIDTH-1:0]           ret_edata,
    input  logic                                           ret_valid,
    output logic                                           ret_ready,
    output logic [BLOCK_SIZE-1:0][OUT_MAN_WIDTH-1:0]       resp_mdata,
    output logic [BLOCK_SIZE-1:0][EXP_WIDTH-1:0]           resp_edata,
    output logic [NUM_REQ-1:0]                             resp_valid,
    input  logic [NUM_REQ-1:0]                             resp_ready,
    output logic [$clog2(MAX_INFLIGHT):0]                  inflight,
    output logic                                           err_orphan
);

    localparam int unsigned TAG_W = $clog2(NUM_REQ);
    localparam int unsigned PTR_W = $clog2(MAX_INFLIGHT);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W-1:0] rr_next;
    logic [TAG_W-1:0] win_idx;
    logic             win_found;
    logic [BLOCK_SIZE-1:0][MAN_WIDTH-1:0] win_mdata;

    logic [TAG_W-1:0] tag_mem [MAX_INFLIGHT];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [TAG_W-1:0] head;
    logic             fifo_empty;

    logic slot_free;
    logic can_issue;
    logic grant;
    logic pop;

    // Issue slot: free when empty or draining this cycle; occupancy is taken
    // before any same-cycle pop, so a full FIFO blocks a grant regardless.
    assign slot_free  = !exp_valid || exp_ready;
    assign can_issue  = rst && slot_free && (count < CNT_W'(MAX_INFLIGHT));
    assign grant      = can_issue && win_found;

    // Round-robin search starting at rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        int unsigned cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(rr_ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_found && req_valid[TAG_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = TAG_W'(cand);
            end
        end
    end

    // Winner's mantissa block.
    always_comb begin
        win_mdata = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (win_idx == TAG_W'(r)) begin
                win_mdata = req_mdata[r*BLOCK_SIZE +: BLOCK_SIZE];
            end
        end
    end

    assign rr_next = (32'(win_idx) + 1 == NUM_REQ) ? '0 : win_idx + TAG_W'(1);

    // Grant vector: only the winner sees ready, and only when issue is possible.
    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    // Return path: routed by the FIFO head, stray results are swallowed.
    assign fifo_empty = (count == '0);
    assign head       = tag_mem[rd_ptr];
    assign resp_mdata = ret_mdata;
    assign resp_edata = ret_edata;

    always_comb begin
        resp_valid = '0;
        ret_ready  = 1'b0;
        if (rst) begin
            if (fifo_empty) begin
                ret_ready = 1'b1;
            end else begin
                ret_ready        = resp_ready[head];
                resp_valid[head] = ret_valid;
            end
        end
    end

    assign pop      = ret_valid && ret_ready && !fifo_empty;
    assign inflight = count;

    // Issue register, round-robin pointer, FIFO pointers, occupancy, orphan flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_valid  <= 1'b0;
            exp_mdata  <= '0;
            exp_edata  <= '0;
            rr_ptr     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err_orphan <= 1'b0;
        end else begin
            if (grant) begin
                exp_valid <= 1'b1;
                exp_mdata <= win_mdata;
                exp_edata <= req_edata[win_idx];
                rr_ptr    <= rr_next;
                wr_ptr    <= wr_ptr + PTR_W'(1);
            end else if (exp_ready) begin
                exp_valid <= 1'b0;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(grant) - CNT_W'(pop);
            if (ret_valid && fifo_empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: entries are only read below the occupancy.
    always_ff @(posedge clk) begin
        if (grant) begin
            tag_mem[wr_ptr] <= win_idx;
        end
    end

endmodule

// File: tb/tb_mxint_exp_arbiter.sv
// Bench for mxint_exp_arbiter: a cycle table from reset followed by
// sequences for streaming, fairness, backpressure and orphan/reset.
module tb_mxint_exp_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic [15:0][3:0] req_mdata;
    logic [3:0][7:0]  req_edata;
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    logic [3:0][3:0]  exp_mdata;
    logic [7:0]       exp_edata;
    logic             exp_valid;
    logic             exp_ready;
    logic [3:0][3:0]  ret_mdata;
    logic [3:0][7:0]  ret_edata;
    logic             ret_valid;
    logic             ret_ready;
    logic [3:0][3:0]  resp_mdata;
    logic [3:0][7:0]  resp_edata;
    logic [3:0]       resp_valid;
    logic [3:0]       resp_ready;
    logic [2:0]       inflight;
    logic             err_orphan;

    always #5 clk = ~clk;

    mxint_exp_arbiter #(
        .NUM_REQ(4), .MAN_WIDTH(4), .EXP_WIDTH(8), .OUT_MAN_WIDTH(4),
        .BLOCK_SIZE(4), .MAX_INFLIGHT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_mdata(req_mdata), .req_edata(req_edata), .req_valid(req_valid), .req_ready(req_ready),
        .exp_mdata(exp_mdata), .exp_edata(exp_edata), .exp_valid(exp_valid), .exp_ready(exp_ready),
        .ret_mdata(ret_mdata), .ret_edata(ret_edata), .ret_valid(ret_valid), .ret_ready(ret_ready),
        .resp_mdata(resp_mdata), .resp_edata(resp_edata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .inflight(inflight), .err_orphan(err_orphan)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] rv;
        logic       er;
        logic       tv;
        logic [3:0] rr;
        logic [3:0] x_rdy;
        logic       x_ev;
        logic [2:0] x_inf;
        logic [3:0] x_rsp;
        logic       x_trdy;
        int         x_src;
    } vec_t;

    typedef struct {
        logic [15:0] m;
        logic [7:0]  e;
        int          due;
    } ment_t;

    vec_t  tbl[13];
    ment_t m_q[$];
    int    grant_q[$];
    int    seq_q[$];
    int    gcnt[4];
    int    peak;
    int    cyc;
    int    seq_iss;
    int    rcvd;
    logic  model_on;
    logic  data_chk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] rv, input logic er, input logic tv,
                                input logic [3:0] rr, input logic [3:0] x_rdy, input logic x_ev,
                                input logic [2:0] x_inf, input logic [3:0] x_rsp,
                                input logic x_trdy, input int x_src);
        vec_t v;
        v.rv = rv; v.er = er; v.tv = tv; v.rr = rr;
        v.x_rdy = x_rdy; v.x_ev = x_ev; v.x_inf = x_inf; v.x_rsp = x_rsp;
        v.x_trdy = x_trdy; v.x_src = x_src;
        return v;
    endfunction

    function automatic logic [15:0] blk(input int r);
        logic [15:0] b;
        for (int k = 0; k < 4; k++) b[k*4 +: 4] = 4'(r*4 + k + 1);
        return b;
    endfunction

    function automatic logic [15:0] exp_m(input int s);
        logic [15:0] b;
        for (int k = 0; k < 4; k++) b[k*4 +: 4] = ~4'(s + k);
        return b;
    endfunction

    function automatic logic [31:0] exp_e(input int s);
        logic [31:0] b;
        for (int k = 0; k < 4; k++) b[k*8 +: 8] = 8'(s) + 8'(k);
        return b;
    endfunction

    task automatic set_default();
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) req_mdata[r*4 + k] = 4'(r*4 + k + 1);
            req_edata[r] = 8'(16 * (r + 1));
        end
    endtask

    task automatic set_req2(input int s);
        for (int k = 0; k < 4; k++) req_mdata[8 + k] = 4'(s + k);
        req_edata[2] = 8'(s);
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        req_valid  = 4'b0;
        exp_ready  = 1'b1;
        ret_valid  = 1'b0;
        ret_mdata  = '0;
        ret_edata  = '0;
        resp_ready = 4'b1111;
        model_on   = 1'b0;
        data_chk   = 1'b0;
        m_q.delete();
        grant_q.delete();
        seq_q.delete();
        for (int r = 0; r < 4; r++) gcnt[r] = 0;
        peak = 0; cyc = 0; seq_iss = 0; rcvd = 0;
        set_default();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // One clock: sample handshakes at negedge, then advance the exp-unit model.
    task automatic step();
        logic [3:0]  hs_req;
        logic        hs_exp;
        logic        hs_ret;
        logic [15:0] em;
        logic [7:0]  ee;
        int          s;
        @(negedge clk);
        hs_req = req_valid & req_ready;
        hs_exp = exp_valid & exp_ready;
        hs_ret = ret_valid & ret_ready;
        em = exp_mdata;
        ee = exp_edata;
        if (32'(inflight) > peak) peak = 32'(inflight);
        for (int r = 0; r < 4; r++) begin
            if (hs_req[r]) begin
                grant_q.push_back(r);
                gcnt[r]++;
                if (data_chk) seq_q.push_back(seq_iss);
            end
        end
        if (data_chk && hs_ret) begin
            if (seq_q.size() == 0) begin
                chk("result_without_issue", 32'(1), 32'(0));
            end else begin
                s = seq_q.pop_front();
                chk("resp_owner", 32'(resp_valid), 32'(4'b0100));
                chk("resp_mdata", 32'(resp_mdata), 32'(exp_m(s)));
                chk("resp_edata", resp_edata, exp_e(s));
                rcvd++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (data_chk && hs_req[2]) begin
            seq_iss++;
            set_req2(seq_iss);
            if (seq_iss == 8) req_valid = 4'b0;
        end
        if (model_on) begin
            if (hs_ret && m_q.size() > 0) m_q.delete(0);
            if (hs_exp) m_q.push_back('{m: em, e: ee, due: cyc + 2});
            if (m_q.size() > 0 && m_q[0].due <= cyc) begin
                ret_valid = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    ret_mdata[k] = ~m_q[0].m[k*4 +: 4];
                    ret_edata[k] = m_q[0].e + 8'(k);
                end
            end else begin
                ret_valid = 1'b0;
            end
        end
    endtask

    initial begin
        // Cycle table from reset: issue, hold, consumer stall, pops, full FIFO.
        tbl[0]  = mk(4'b0100, 1, 0, 4'b1111, 4'b0100, 0, 3'd0, 4'b0000, 1, -1);
        tbl[1]  = mk(4'b1111, 1, 0, 4'b1111, 4'b1000, 1, 3'd1, 4'b0000, 1,  2);
        tbl[2]  = mk(4'b1111, 0, 0, 4'b1111, 4'b0000, 1, 3'd2, 4'b0000, 1,  3);
        tbl[3]  = mk(4'b0000, 1, 1, 4'b1011, 4'b0000, 1, 3'd2, 4'b0100, 0,  3);
        tbl[4]  = mk(4'b0010, 1, 1, 4'b1111, 4'b0010, 0, 3'd2, 4'b0100, 1, -1);
        tbl[5]  = mk(4'b0001, 1, 1, 4'b1111, 4'b0001, 1, 3'd2, 4'b1000, 1,  1);
        tbl[6]  = mk(4'b0001, 1, 0, 4'b1111, 4'b0001, 1, 3'd2, 4'b0000, 1,  0);
        tbl[7]  = mk(4'b0001, 1, 0, 4'b1111, 4'b0001, 1, 3'd3, 4'b0000, 1,  0);
        tbl[8]  = mk(4'b0001, 1, 1, 4'b1111, 4'b0000, 1, 3'd4, 4'b0010, 1,  0);
        tbl[9]  = mk(4'b0001, 1, 0, 4'b1111, 4'b0001, 0, 3'd3, 4'b0000, 1, -1);
        tbl[10] = mk(4'b0010, 1, 1, 4'b1110, 4'b0000, 1, 3'd4, 4'b0001, 0,  0);
        tbl[11] = mk(4'b0010, 1, 1, 4'b1111, 4'b0000, 0, 3'd4, 4'b0001, 1, -1);
        tbl[12] = mk(4'b0010, 1, 0, 4'b1111, 4'b0010, 0, 3'd3, 4'b0000, 1, -1);

        // Reset values while rst is held low with active inputs.
        rst = 1'b0;
        set_default();
        req_valid = 4'b1111; exp_ready = 1'b1; ret_valid = 1'b1;
        resp_ready = 4'b1111; ret_mdata = '0; ret_edata = '0;
        model_on = 1'b0; data_chk = 1'b0;
        #12;
        chk("rst_exp_valid", 32'(exp_valid), 32'(0));
        chk("rst_exp_data", {exp_mdata, exp_edata}, 32'(0));
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_ret_ready", 32'(ret_ready), 32'(0));
        chk("rst_resp_valid", 32'(resp_valid), 32'(0));
        chk("rst_inflight", 32'(inflight), 32'(0));
        chk("rst_err_orphan", 32'(err_orphan), 32'(0));

        do_reset();
        for (int i = 0; i < 13; i++) begin
            req_valid  = tbl[i].rv;
            exp_ready  = tbl[i].er;
            ret_valid  = tbl[i].tv;
            resp_ready = tbl[i].rr;
            for (int k = 0; k < 4; k++) begin
                ret_mdata[k] = 4'(i + k);
                ret_edata[k] = 8'(8'h40 + 8'(i) + 8'(k));
            end
            @(negedge clk);
            chk($sformatf("tbl%0d_req_ready", i), 32'(req_ready), 32'(tbl[i].x_rdy));
            chk($sformatf("tbl%0d_exp_valid", i), 32'(exp_valid), 32'(tbl[i].x_ev));
            chk($sformatf("tbl%0d_inflight", i), 32'(inflight), 32'(tbl[i].x_inf));
            chk($sformatf("tbl%0d_resp_valid", i), 32'(resp_valid), 32'(tbl[i].x_rsp));
            chk($sformatf("tbl%0d_ret_ready", i), 32'(ret_ready), 32'(tbl[i].x_trdy));
            if (tbl[i].x_src >= 0) begin
                chk($sformatf("tbl%0d_exp_mdata", i), 32'(exp_mdata), 32'(blk(tbl[i].x_src)));
                chk($sformatf("tbl%0d_exp_edata", i), 32'(exp_edata), 32'(16 * (tbl[i].x_src + 1)));
            end
            if (i == 3) begin
                chk("passthru_mdata", 32'(resp_mdata), 32'(16'h6543));
                chk("passthru_edata", resp_edata, 32'h46454443);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("tbl_no_orphan", 32'(err_orphan), 32'(0));

        // Single requester streaming through a 3-cycle exp model.
        do_reset();
        model_on = 1'b1; data_chk = 1'b1;
        set_req2(0);
        req_valid = 4'b0100;
        for (int c = 0; c < 200 && rcvd < 8; c++) step();
        chk("single_results", 32'(rcvd), 32'(8));
        chk("single_grants", 32'(gcnt[2]), 32'(8));
        chk("single_peak", 32'(peak), 32'(4));
        chk("single_drained", 32'(inflight), 32'(0));

        // Round-robin fairness with all requesters valid.
        do_reset();
        model_on = 1'b1;
        req_valid = 4'b1111;
        for (int c = 0; c < 300 && grant_q.size() < 16; c++) step();
        chk("rr_grant_total", 32'(grant_q.size()), 32'(16));
        for (int i = 0; i < 16 && i < grant_q.size(); i++)
            chk($sformatf("rr_order%0d", i), 32'(grant_q[i]), 32'(i % 4));
        for (int r = 0; r < 4; r++)
            chk($sformatf("rr_count%0d", r), 32'(gcnt[r]), 32'(4));

        // Backpressure: exp_ready low for five cycles after a grant to req 0.
        do_reset();
        req_valid = 4'b1111;
        step();
        exp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_req_ready", c), 32'(req_ready), 32'(0));
            chk($sformatf("bp%0d_exp_valid", c), 32'(exp_valid), 32'(1));
            chk($sformatf("bp%0d_exp_mdata", c), 32'(exp_mdata), 32'(blk(0)));
            chk($sformatf("bp%0d_exp_edata", c), 32'(exp_edata), 32'(16));
            chk($sformatf("bp%0d_inflight", c), 32'(inflight), 32'(1));
            @(posedge clk);
            #1;
        end
        exp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_grant", 32'(req_ready), 32'(4'b0010));
        @(posedge clk);
        #1;
        chk("bp_release_data", 32'(exp_mdata), 32'(blk(1)));
        chk("bp_release_inflight", 32'(inflight), 32'(2));

        // Orphan result, then reset with three blocks in flight.
        do_reset();
        ret_valid = 1'b1;
        @(negedge clk);
        chk("orphan_ret_ready", 32'(ret_ready), 32'(1));
        chk("orphan_resp_valid", 32'(resp_valid), 32'(0));
        @(posedge clk);
        #1 ret_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("orphan_sticky", 32'(err_orphan), 32'(1));
        @(posedge clk);
        #1 req_valid = 4'b1111;
        repeat (3) @(posedge clk);
        #1 ret_valid = 1'b1;
        resp_ready = 4'b0000;
        @(negedge clk);
        chk("pre_rst_inflight", 32'(inflight), 32'(3));
        rst = 1'b0;
        #1;
        chk("mid_rst_exp_valid", 32'(exp_valid), 32'(0));
        chk("mid_rst_inflight", 32'(inflight), 32'(0));
        chk("mid_rst_err_orphan", 32'(err_orphan), 32'(0));
        chk("mid_rst_req_ready", 32'(req_ready), 32'(0));
        chk("mid_rst_ret_ready", 32'(ret_ready), 32'(0));
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        req_valid = 4'b0000;
        @(negedge clk);
        chk("post_rst_resp_valid", 32'(resp_valid), 32'(0));
        chk("post_rst_ret_ready", 32'(ret_ready), 32'(1));
        @(posedge clk);
        #1 ret_valid = 1'b0;
        chk("post_rst_orphan", 32'(err_orphan), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
